coherent_bus_ctrl: RTL and testbench
====================================

Name: coherent_bus_ctrl

Overview:
- N-CPU memory controller and coherence arbiter between the per-CPU L1 caches and the single-port RAM.
- Grants one request at a time to RAM, with round-robin fairness among CPUs. Data requests take priority over instruction fetches.
- Before any coherent data access, snoops every other cache. Can invalidate remote copies. Supports dirty-line writeback with cache-to-cache forwarding to the requester.

Parameters:
CPUS, 2, number of CPUs/caches (2..8)
SNOOP_CYCLES, 1, cycles snoop addr/ccwait held before snooper responses are sampled (1..4)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, synchronous, active-low
iREN  in  CPUS  per-CPU instruction read request
iaddr  in  CPUS*32  per-CPU instruction word address, CPU k at bits [32k+31:32k]
dREN  in  CPUS  per-CPU data read request
dWEN  in  CPUS  per-CPU data write request (also snooper writeback response)
daddr  in  CPUS*32  per-CPU data address
dstore  in  CPUS*32  per-CPU data to store/write back
cctrans  in  CPUS  request is coherent, needs snoop
ccwrite  in  CPUS  coherent request is for ownership (invalidate others)
iwait  out  CPUS  instruction stall, 1=wait
dwait  out  CPUS  data stall, 1=wait
iload  out  CPUS*32  instruction return data
dload  out  CPUS*32  data return data
ccwait  out  CPUS  cache is being snooped, must service snoop
ccinv  out  CPUS  invalidate line at ccsnoopaddr
ccsnoopaddr  out  CPUS*32  snoop address
ramREN  out  1  RAM read
ramWEN  out  1  RAM write
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Reset (nRST low at CLK edge): state=IDLE, rr_ptr=0. All iwait/dwait=1. All other outputs 0. Mid-transaction reset drops the request silently; requester sees wait held.
- States: IDLE, SNOOP, RESP, WB, DRD, DWR, IRD.
- IDLE, arbitration:
  - Candidate set is CPUs with dREN|dWEN; if empty, CPUs with iREN.
  - Winner is the first candidate at or after rr_ptr, modulo CPUS. winner is registered and stays fixed for the whole transaction.
  - Data winner with cctrans -> SNOOP.
  - Data winner without cctrans -> DRD if dREN, else DWR (dREN wins if both set).
  - Instruction winner -> IRD.
  - No request -> stay IDLE.
- SNOOP: for every k != winner, ccwait[k]=1, ccsnoopaddr[k]=daddr[winner], ccinv[k]=ccwrite[winner]. Hold SNOOP_CYCLES cycles (counter), then -> RESP with the same outputs.
- RESP: lowest-index snooper with dWEN=1 becomes owner -> WB. No owner -> DRD/DWR per winner's request.
- WB: ccwait/snoop outputs held. ramWEN=1, ramaddr=daddr[owner], ramstore=dstore[owner].
  - If winner dREN: dload[winner]=dstore[owner].
  - On ramstate==ACCESS: dwait[owner]=0; dwait[winner]=0 only if winner dREN; then -> IDLE.
  - Winner dWEN: the request is not retired; it re-arbitrates.
- DRD: ramREN=1, ramaddr=daddr[winner], dload[winner]=ramload. On ACCESS: dwait[winner]=0, -> IDLE.
- DWR: ramWEN=1, ramaddr=daddr[winner], ramstore=dstore[winner]. On ACCESS: dwait[winner]=0, -> IDLE.
- IRD: ramREN=1, ramaddr=iaddr[winner], iload[winner]=ramload. On ACCESS: iwait[winner]=0, -> IDLE.
- Each wait deasserts for exactly the one ACCESS cycle. Every other wait bit stays 1 at all times.
- rr_ptr updates to winner+1 mod CPUS on every completing ACCESS cycle.
- ramstate FREE/BUSY/ERROR: hold state, all waits 1. ERROR is treated as BUSY.
- Requester drops its request mid-state: DRD/DWR/IRD abort -> IDLE next cycle with no wait pulse. SNOOP/RESP/WB complete regardless.
- Latency, uncontended non-coherent read: 1 cycle in IDLE + RAM latency. Coherent read adds SNOOP_CYCLES+1 cycles.

Optional Feature:
- Macro: COHERENT_BUS_STATS_EN.
- Defined: adds outputs snoop_cnt[31:0] and c2c_cnt[31:0].
  - snoop_cnt increments on each SNOOP entry.
  - c2c_cnt increments on each WB completion.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- CPUS=2, CPU0 dREN daddr=0x100 no cctrans, RAM ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x100, dload[0]=0xDEADBEEF, dwait[0] low for one cycle; dwait[1], iwait[0], iwait[1] stay 1.
- CPU0 and CPU1 both dREN continuously, ramstate always ACCESS -> grants alternate 0,1,0,1; iREN[0] is not served until both data requests drop.
- CPU1 cctrans+ccwrite+dWEN daddr=0x200 -> ccwait[0]=1, ccinv[0]=1, ccsnoopaddr[0]=0x200 for SNOOP_CYCLES+1 cycles, then DWR of dstore[1] to 0x200.
- CPU0 coherent dREN 0x300, CPU1 answers dWEN=1 with dstore[1]=0xCAFE0001 -> ramWEN to 0x300 with 0xCAFE0001, dload[0]=0xCAFE0001, dwait[0] and dwait[1] low in the same ACCESS cycle.
- nRST low during DRD -> next cycle state IDLE, ramREN=0, all waits 1. With COHERENT_BUS_STATS_EN, 3 coherent requests with 1 writeback -> snoop_cnt=3, c2c_cnt=1.

Source files
------------

// File: rtl/coherent_bus_ctrl.sv
// Coherent memory controller: round-robin arbiter between per-CPU L1 caches and one RAM port,
// with snooping, invalidation and dirty-line forwarding. Optional stats counters: COHERENT_BUS_STATS_EN.
module coherent_bus_ctrl #(
  parameter int CPUS         = 2,
  parameter int SNOOP_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS*32-1:0]   iaddr,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS*32-1:0]   daddr,
  input  logic [CPUS*32-1:0]   dstore,
  input  logic [CPUS-1:0]      cctrans,
  input  logic [CPUS-1:0]      ccwrite,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS*32-1:0]   iload,
  output logic [CPUS*32-1:0]   dload,
  output logic [CPUS-1:0]      ccwait,
  output logic [CPUS-1:0]      ccinv,
  output logic [CPUS*32-1:0]   ccsnoopaddr,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate,
  output logic [2:0]           dbg_state_o
`ifdef COHERENT_BUS_STATS_EN
  ,
  output logic [31:0]          snoop_cnt,
  output logic [31:0]          c2c_cnt
`endif
);

  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int CW = (SNOOP_CYCLES > 1) ? $clog2(SNOOP_CYCLES) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SNOOP = 3'd1,
    S_RESP  = 3'd2,
    S_WB    = 3'd3,
    S_DRD   = 3'd4,
    S_DWR   = 3'd5,
    S_IRD   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] winner_q, winner_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [CPUS-1:0] dreq, cand;
  logic            found;
  logic [IW-1:0]   pick;
  logic            resp_found;
  logic [IW-1:0]   resp_owner;
  logic            access;
  logic [IW-1:0]   rr_next;
  logic [31:0]     w_daddr, w_dstore, w_iaddr, o_daddr, o_dstore;
  logic            w_dren, w_dwen, w_iren, w_ccwrite;

  assign access    = (ramstate == RAM_ACCESS);
  assign rr_next   = (winner_q == IW'(CPUS - 1)) ? '0 : winner_q + 1'b1;
  assign w_daddr   = daddr[winner_q*32 +: 32];
  assign w_dstore  = dstore[winner_q*32 +: 32];
  assign w_iaddr   = iaddr[winner_q*32 +: 32];
  assign o_daddr   = daddr[owner_q*32 +: 32];
  assign o_dstore  = dstore[owner_q*32 +: 32];
  assign w_dren    = dREN[winner_q];
  assign w_dwen    = dWEN[winner_q];
  assign w_iren    = iREN[winner_q];
  assign w_ccwrite = ccwrite[winner_q];
  assign dbg_state_o = state_q;

  // Data requests shadow instruction fetches entirely; search starts at the round-robin pointer.
  always_comb begin
    dreq  = dREN | dWEN;
    cand  = (|dreq) ? dreq : iREN;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < CPUS; i++) begin
      if (!found && cand[(int'(rr_q) + i) % CPUS]) begin
        found = 1'b1;
        pick  = IW'((int'(rr_q) + i) % CPUS);
      end
    end
  end

  always_comb begin
    resp_found = 1'b0;
    resp_owner = '0;
    for (int k = 0; k < CPUS; k++) begin
      if (!resp_found && dWEN[k] && (k != int'(winner_q))) begin
        resp_found = 1'b1;
        resp_owner = IW'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          winner_d = pick;
          cnt_d    = '0;
          if (|dreq) begin
            if (cctrans[pick])   state_d = S_SNOOP;
            else if (dREN[pick]) state_d = S_DRD;
            else                 state_d = S_DWR;
          end else begin
            state_d = S_IRD;
          end
        end
      end
      S_SNOOP: begin
        if (cnt_q == CW'(SNOOP_CYCLES - 1)) state_d = S_RESP;
        else                                cnt_d   = cnt_q + 1'b1;
      end
      S_RESP: begin
        if (resp_found) begin
          owner_d = resp_owner;
          state_d = S_WB;
        end else if (w_dren) begin
          state_d = S_DRD;
        end else begin
          state_d = S_DWR;
        end
      end
      // A writing winner is not retired by the writeback; it simply re-arbitrates.
      S_WB: begin
        if (access) begin
          rr_d    = rr_next;
          state_d = S_IDLE;
        end
      end
      S_DRD: begin
        if (!w_dren) state_d = S_IDLE;
        else if (access) begin
          rr_d    = rr_next;
          state_d = S_IDLE;
        end
      end
      S_DWR: begin
        if (!w_dwen) state_d = S_IDLE;
        else if (access) begin
          rr_d    = rr_next;
          state_d = S_IDLE;
        end
      end
      S_IRD: begin
        if (!w_iren) state_d = S_IDLE;
        else if (access) begin
          rr_d    = rr_next;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      winner_q <= '0;
      owner_q  <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
    end
  end

  // RAM strobes never look at ramstate, which keeps the RAM handshake free of combinational loops.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      S_WB: begin
        ramWEN   = 1'b1;
        ramaddr  = o_daddr;
        ramstore = o_dstore;
      end
      S_DRD: begin
        if (w_dren) begin
          ramREN  = 1'b1;
          ramaddr = w_daddr;
        end
      end
      S_DWR: begin
        if (w_dwen) begin
          ramWEN   = 1'b1;
          ramaddr  = w_daddr;
          ramstore = w_dstore;
        end
      end
      S_IRD: begin
        if (w_iren) begin
          ramREN  = 1'b1;
          ramaddr = w_iaddr;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    case (state_q)
      S_SNOOP, S_RESP, S_WB: begin
        for (int k = 0; k < CPUS; k++) begin
          if (k != int'(winner_q)) begin
            ccwait[k]             = 1'b1;
            ccinv[k]              = w_ccwrite;
            ccsnoopaddr[k*32 +: 32] = w_daddr;
          end
        end
        if (state_q == S_WB) begin
          if (w_dren) dload[winner_q*32 +: 32] = o_dstore;
          if (access) begin
            dwait[owner_q] = 1'b0;
            if (w_dren) dwait[winner_q] = 1'b0;
          end
        end
      end
      S_DRD: begin
        if (w_dren) begin
          dload[winner_q*32 +: 32] = ramload;
          if (access) dwait[winner_q] = 1'b0;
        end
      end
      S_DWR: begin
        if (w_dwen && access) dwait[winner_q] = 1'b0;
      end
      S_IRD: begin
        if (w_iren) begin
          iload[winner_q*32 +: 32] = ramload;
          if (access) iwait[winner_q] = 1'b0;
        end
      end
      default: ;
    endcase
  end

`ifdef COHERENT_BUS_STATS_EN
  logic [31:0] snoop_cnt_q, c2c_cnt_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      snoop_cnt_q <= '0;
      c2c_cnt_q   <= '0;
    end else begin
      if (state_q == S_IDLE && state_d == S_SNOOP && snoop_cnt_q != 32'hFFFF_FFFF)
        snoop_cnt_q <= snoop_cnt_q + 32'd1;
      if (state_q == S_WB && access && c2c_cnt_q != 32'hFFFF_FFFF)
        c2c_cnt_q <= c2c_cnt_q + 32'd1;
    end
  end

  assign snoop_cnt = snoop_cnt_q;
  assign c2c_cnt   = c2c_cnt_q;
`endif

endmodule

// File: tb/tb_coherent_bus_ctrl.sv
// Directed bench for coherent_bus_ctrl: expected completions queued by the drivers, checked by a monitor.
module tb_coherent_bus_ctrl;
  localparam int CPUS = 2;
  localparam int SC   = 1;
  localparam int W    = 2 + 2 + 1 + 1 + 32 + 32 + 64 + 64;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [CPUS-1:0]   iREN, dREN, dWEN, cctrans, ccwrite;
  logic [CPUS*32-1:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]   iwait, dwait, ccwait, ccinv;
  logic [CPUS*32-1:0] iload, dload, ccsnoopaddr;
  logic              ramREN, ramWEN;
  logic [31:0]       ramaddr, ramstore, ramload;
  logic [1:0]        ramstate;
  logic [2:0]        dbg_state;
`ifdef COHERENT_BUS_STATS_EN
  logic [31:0]       snoop_cnt, c2c_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs, exp_v;

  int          ram_lat = 0;
  bit          ram_err = 1'b0;
  int          ram_cnt = 0;
  logic [31:0] ram_data = 32'h0;

  coherent_bus_ctrl #(.CPUS(CPUS), .SNOOP_CYCLES(SC)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .cctrans(cctrans), .ccwrite(ccwrite),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .dbg_state_o(dbg_state)
`ifdef COHERENT_BUS_STATS_EN
    , .snoop_cnt(snoop_cnt), .c2c_cnt(c2c_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // RAM model: BUSY (or ERROR) for ram_lat cycles of a held request, then ACCESS.
  always @(posedge CLK) begin
    if ((ramREN || ramWEN) && ramstate != 2'd2) ram_cnt <= ram_cnt + 1;
    else                                       ram_cnt <= 0;
  end
  assign ramstate = !(ramREN || ramWEN) ? 2'd0 :
                    (ram_cnt >= ram_lat) ? 2'd2 : (ram_err ? 2'd3 : 2'd1);
  assign ramload  = ram_data;

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ram_lat = 0; ram_err = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] dwn, input logic [1:0] iwn,
                                      input logic ren, input logic wen,
                                      input logic [31:0] addr, input logic [31:0] store,
                                      input logic [63:0] dl, input logic [63:0] il);
    return {dwn, iwn, ren, wen, addr, store, dl, il};
  endfunction

  // Monitor: every cycle with any wait low is one completion record.
  initial begin
    forever begin
      @(negedge CLK);
      if (nRST === 1'b1 && (dwait !== 2'b11 || iwait !== 2'b11)) begin
        obs = {~dwait, ~iwait, ramREN, ramWEN, ramaddr, ramstore, dload, iload};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL txn: unexpected completion got=%h", obs);
        end else begin
          exp_v = exp_q.pop_front();
          if (obs !== exp_v) begin
            errors++;
            $display("FAIL txn: got=%h exp=%h", obs, exp_v);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic data_txn(input int cpu, input bit wr, input bit coh, input bit inv,
                          input logic [31:0] addr, input logic [31:0] store,
                          input bit wb, input logic [31:0] wb_data,
                          output int cycles, output int snp_ok, output int snp_any);
    int other;
    bit done;
    bit responded;
    logic [1:0] mask;
    other = 1 - cpu;
    mask = 2'b01 << other;
    cycles = 0; snp_ok = 0; snp_any = 0; done = 1'b0; responded = 1'b0;
    daddr[cpu*32 +: 32]  = addr;
    dstore[cpu*32 +: 32] = store;
    dREN[cpu] = !wr; dWEN[cpu] = wr; cctrans[cpu] = coh; ccwrite[cpu] = inv;
    while (!done && cycles < 100) begin
      @(negedge CLK);
      cycles++;
      if (ccwait != 2'b00) snp_any++;
      if (ccwait == mask && ccsnoopaddr[other*32 +: 32] == addr && ccinv[other] == inv &&
          ccsnoopaddr[cpu*32 +: 32] == 32'h0 && ccinv[cpu] == 1'b0) snp_ok++;
      if (wb && !responded && ccwait[other]) begin
        responded = 1'b1;
        dWEN[other] = 1'b1;
        daddr[other*32 +: 32]  = addr;
        dstore[other*32 +: 32] = wb_data;
      end
      if (!dwait[cpu]) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL txn_timeout: cpu%0d no dwait pulse within 100 cycles", cpu);
    end
    @(posedge CLK); #1;
    dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
  endtask

  task automatic wait_iwait(input int cpu, output int cycles);
    bit done;
    done = 1'b0; cycles = 0;
    while (!done && cycles < 100) begin
      @(negedge CLK);
      cycles++;
      if (!iwait[cpu]) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL ifetch_timeout: cpu%0d no iwait pulse within 100 cycles", cpu);
    end
    @(posedge CLK); #1;
    iREN[cpu] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc, sok, sany, n;

    // Reset state
    nRST = 1'b0;
    clear_inputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_waits", {60'h0, dwait, iwait}, 64'hF);
    chk("rst_cc", {60'h0, ccwait, ccinv}, 64'h0);
    chk("rst_snoopaddr", ccsnoopaddr, 64'h0);
    chk("rst_ram", {30'h0, ramREN, ramWEN, ramaddr}, 64'h0);
    chk("rst_ramstore", 64'(ramstore), 64'h0);
    chk("rst_loads", dload | iload, 64'h0);
    @(posedge CLK); #1 nRST = 1'b1;

    // Uncontended non-coherent read, 2 BUSY cycles
    ram_lat = 2; ram_data = 32'hDEADBEEF;
    exp_q.push_back(mk(2'b01, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0, {32'h0, 32'hDEADBEEF}, 64'h0));
    data_txn(0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, cyc, sok, sany);
    chk("rd_latency", 64'(cyc), 64'd4);
    chk("rd_no_snoop", 64'(sany), 64'd0);

    // Two contending data readers alternate; the instruction fetch waits for both to drop
    do_reset();
    ram_lat = 0; ram_data = 32'h11112222;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(2'b01, 2'b00, 1'b1, 1'b0, 32'h400, 32'h0, {32'h0, 32'h11112222}, 64'h0));
      exp_q.push_back(mk(2'b10, 2'b00, 1'b1, 1'b0, 32'h500, 32'h0, {32'h11112222, 32'h0}, 64'h0));
    end
    exp_q.push_back(mk(2'b00, 2'b01, 1'b1, 1'b0, 32'h40, 32'h0, 64'h0, {32'h0, 32'h11112222}));
    daddr = {32'h500, 32'h400};
    iaddr = {32'h0, 32'h40};
    dREN = 2'b11; iREN = 2'b01;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      if (dwait != 2'b11) n++;
    end
    chk("rr_grants", 64'(n), 64'd4);
    @(posedge CLK); #1 dREN = 2'b00;
    wait_iwait(0, cyc);

    // Coherent write with invalidate, no owner -> DWR
    do_reset();
    ram_lat = 1;
    exp_q.push_back(mk(2'b10, 2'b00, 1'b0, 1'b1, 32'h200, 32'hABCD0200, 64'h0, 64'h0));
    data_txn(1, 1'b1, 1'b1, 1'b1, 32'h200, 32'hABCD0200, 1'b0, 32'h0, cyc, sok, sany);
    chk("cohwr_latency", 64'(cyc), 64'(SC + 4));
    chk("cohwr_snoop_ok", 64'(sok), 64'(SC + 1));
    chk("cohwr_snoop_any", 64'(sany), 64'(SC + 1));

    // Coherent read answered by CPU1 writeback, forwarded to CPU0
    ram_lat = 1;
    exp_q.push_back(mk(2'b11, 2'b00, 1'b0, 1'b1, 32'h300, 32'hCAFE0001, {32'h0, 32'hCAFE0001}, 64'h0));
    data_txn(0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 32'hCAFE0001, cyc, sok, sany);
    chk("c2c_latency", 64'(cyc), 64'(SC + 4));
    chk("c2c_snoop_ok", 64'(sok), 64'(SC + 3));
    chk("c2c_snoop_any", 64'(sany), 64'(SC + 3));

    // Coherent read, no owner, RAM reports ERROR while not ready
    ram_lat = 2; ram_err = 1'b1; ram_data = 32'h55AA55AA;
    exp_q.push_back(mk(2'b01, 2'b00, 1'b1, 1'b0, 32'h340, 32'h0, {32'h0, 32'h55AA55AA}, 64'h0));
    data_txn(0, 1'b0, 1'b1, 1'b0, 32'h340, 32'h0, 1'b0, 32'h0, cyc, sok, sany);
    chk("cohrd_err_latency", 64'(cyc), 64'(SC + 5));
    chk("cohrd_snoop_ok", 64'(sok), 64'(SC + 1));
    ram_err = 1'b0;
`ifdef COHERENT_BUS_STATS_EN
    chk("snoop_cnt", 64'(snoop_cnt), 64'd3);
    chk("c2c_cnt", 64'(c2c_cnt), 64'd1);
`endif

    // Reset in the middle of a RAM read
    do_reset();
    ram_lat = 5;
    daddr[31:0] = 32'h500; dREN[0] = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("drd_state", 64'(dbg_state), 64'd4);
    chk("drd_ram", {31'h0, ramREN, ramaddr}, {31'h0, 1'b1, 32'h500});
    @(posedge CLK); #1 nRST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("midrst_state", 64'(dbg_state), 64'd0);
    chk("midrst_ram", {31'h0, ramREN, ramaddr}, 64'h0);
    chk("midrst_waits", {60'h0, dwait, iwait}, 64'hF);
    dREN = '0;
    @(posedge CLK); #1 nRST = 1'b1;

    // Requester abandons its read: back to IDLE with no wait pulse
    ram_lat = 5;
    daddr[31:0] = 32'h600; dREN[0] = 1'b1;
    @(posedge CLK); #1 dREN[0] = 1'b0;
    @(negedge CLK);
    chk("abort_waits", {62'h0, dwait}, 64'h3);
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_state", 64'(dbg_state), 64'd0);

    // Uncontended instruction fetch with immediate ACCESS
    @(posedge CLK); #1;
    ram_lat = 0; ram_data = 32'h12345678;
    exp_q.push_back(mk(2'b00, 2'b10, 1'b1, 1'b0, 32'h80, 32'h0, 64'h0, {32'h12345678, 32'h0}));
    iaddr = {32'h80, 32'h0}; iREN[1] = 1'b1;
    wait_iwait(1, cyc);
    chk("ifetch_latency", 64'(cyc), 64'd2);

    repeat (5) @(posedge CLK);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
